// File: rtl/vending_coin_datapath_pkg.sv
// Shared constants and coin-select helpers for the vending coin datapath.
// Package name is vending_pkg; the NICKEL_PACE_EN option lives in the top module.
package vending_pkg;

    localparam int NICKEL_VAL      = 5;
    localparam int DIME_VAL        = 10;
    localparam int QUARTER_VAL     = 25;
    localparam int DEFAULT_PRICE   = 100;
    localparam int DEFAULT_MONEY_W = 8;

    typedef enum logic [2:0] {
        NONE,
        NICKEL,
        DIME,
        QUARTER,
        MULTI
    } coin_sel_e;

    // Simultaneous edges collapse to MULTI so the caller can refuse them.
    function automatic coin_sel_e coin_select(input logic nickel, input logic dime,
                                              input logic quarter);
        coin_sel_e sel;
        sel = NONE;
        case ({nickel, dime, quarter})
            3'b000:  sel = NONE;
            3'b100:  sel = NICKEL;
            3'b010:  sel = DIME;
            3'b001:  sel = QUARTER;
            default: sel = MULTI;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/vending_coin_datapath_coin_edge.sv
// Rising-edge detector for one coin sensor line.
// The history register resets to 1 so a line held high through reset gives no edge.
module coin_edge (
    input  logic clk,
    input  logic reset,
    input  logic coin_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= coin_i;
        end
    end

    assign rise_o = coin_i & ~prev_q;

endmodule

// File: rtl/vending_coin_datapath.sv
// Money/change datapath for the vending controller: coin credit, sale count, nickel payout.
// Define NICKEL_PACE_EN to space nickel payouts PACE_CYCLES cycles apart.
module vending_coin_datapath
    import vending_pkg::*;
#(
    parameter int MONEY_W     = DEFAULT_MONEY_W,
    parameter int PRICE       = DEFAULT_PRICE,
    parameter int PACE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_nickel,
    input  logic               coin_dime,
    input  logic               coin_quarter,
    input  logic               collect,
    input  logic               ren,
    input  logic               loadc,
    input  logic               cen,
    output logic               mge100,
    output logic               ceq0,
    output logic [MONEY_W-1:0] money,
    output logic [MONEY_W-1:0] change,
    output logic               dispense_nickel,
    output logic               coin_reject,
    output logic [7:0]         sale_count
);

    localparam logic [MONEY_W-1:0] PRICE_W  = MONEY_W'(PRICE);
    localparam logic [MONEY_W-1:0] NICKEL_W = MONEY_W'(NICKEL_VAL);

    logic               rise_nickel, rise_dime, rise_quarter;
    coin_sel_e          coin_sel;
    logic               any_rise, accept, step, pace_ok;
    logic [MONEY_W-1:0] coin_val;

    logic [MONEY_W-1:0] money_q, money_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [7:0]         sale_q, sale_d;
    logic               dispense_q, dispense_d;
    logic               reject_q, reject_d;

    coin_edge u_edge_nickel  (.clk(clk), .reset(reset), .coin_i(coin_nickel),  .rise_o(rise_nickel));
    coin_edge u_edge_dime    (.clk(clk), .reset(reset), .coin_i(coin_dime),    .rise_o(rise_dime));
    coin_edge u_edge_quarter (.clk(clk), .reset(reset), .coin_i(coin_quarter), .rise_o(rise_quarter));

    assign coin_sel = coin_select(rise_nickel, rise_dime, rise_quarter);
    assign any_rise = (coin_sel != NONE);
    assign mge100   = (money_q >= PRICE_W);
    assign ceq0     = (change_q == '0);
    assign accept   = collect && !mge100 &&
                      (coin_sel == NICKEL || coin_sel == DIME || coin_sel == QUARTER);
    assign step     = cen && !loadc && !ceq0 && pace_ok;

    always_comb begin
        coin_val = '0;
        case (coin_sel)
            NICKEL:  coin_val = MONEY_W'(NICKEL_VAL);
            DIME:    coin_val = MONEY_W'(DIME_VAL);
            QUARTER: coin_val = MONEY_W'(QUARTER_VAL);
            default: coin_val = '0;
        endcase
    end

`ifdef NICKEL_PACE_EN
    localparam int PACE_W = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;

    logic [PACE_W-1:0] pace_q, pace_d;

    assign pace_ok = (pace_q == '0);

    always_comb begin
        pace_d = pace_q;
        if (!cen) begin
            pace_d = '0;
        end else if (step) begin
            pace_d = PACE_W'(PACE_CYCLES - 1);
        end else if (pace_q != '0) begin
            pace_d = pace_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pace_q <= '0;
        end else begin
            pace_q <= pace_d;
        end
    end
`else
    assign pace_ok = 1'b1;
`endif

    // loadc outranks both a coin credit and a payout step; the guard keeps change from wrapping.
    always_comb begin
        money_d    = money_q;
        change_d   = change_q;
        sale_d     = sale_q + {7'd0, ren};
        reject_d   = any_rise && !accept;
        dispense_d = step;
        if (loadc) begin
            money_d  = '0;
            change_d = mge100 ? (money_q - PRICE_W) : '0;
        end else begin
            if (accept) begin
                money_d = money_q + coin_val;
            end
            if (step) begin
                change_d = change_q - NICKEL_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            money_q    <= '0;
            change_q   <= '0;
            sale_q     <= '0;
            dispense_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            money_q    <= money_d;
            change_q   <= change_d;
            sale_q     <= sale_d;
            dispense_q <= dispense_d;
            reject_q   <= reject_d;
        end
    end

    assign money           = money_q;
    assign change          = change_q;
    assign sale_count      = sale_q;
    assign dispense_nickel = dispense_q;
    assign coin_reject     = reject_q;

endmodule
